// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank
// ----------------
// Bank of NumCounters hardware performance-monitor counters for the CVA6
// core. Each counter picks one line of events_i at runtime and counts it
// either as a level (every active cycle) or as a rising edge. A counter can
// be inhibited on its own. When a counter wraps it sets a sticky overflow
// flag, which can raise irq_o. The CSR file reaches the bank through a
// small register-access port. Reads on that port are combinational.
//
// Ports:
//   clk_i, rst_ni  clock; asynchronous active-low reset
//   debug_mode_i   freezes all counting (CSR writes still land)
//   events_i       per-cycle event strobes, NumEvents wide
//   cnt_idx_i      counter index of the access
//   reg_sel_i      0 = COUNT, 1 = COUNTH, 2 = CTRL, 3 = OVF
//   we_i, re_i     write / read strobes (re_i only qualifies err_o)
//   wdata_i        write data, XLEN wide
//   rdata_o        combinational read data
//   err_o          combinational illegal-access flag
//   irq_o          OR of (overflow & irq enable) over all counters
//
// CTRL layout: [SelW-1:0] sel, [8] edge, [9] irqen, [10] inhibit,
//              [15] ovf (read-only), all other bits read 0.

module hpm_counter_bank #(
  parameter int unsigned NumCounters = 8,
  parameter int unsigned NumEvents   = 32,
  parameter int unsigned CntWidth    = 64,
  parameter int unsigned XLEN        = 64,
  localparam int unsigned SelW       = $clog2(NumEvents + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 debug_mode_i,
  input  logic [NumEvents-1:0] events_i,
  input  logic [4:0]           cnt_idx_i,
  input  logic [1:0]           reg_sel_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [XLEN-1:0]      wdata_i,
  output logic [XLEN-1:0]      rdata_o,
  output logic                 err_o,
  output logic                 irq_o
);

  // The event vectors are widened to 2**SelW entries with a zero at index
  // 0, so a select value can index them directly. sel==0 and any
  // sel>NumEvents then land on a constant 0 and never count.
  localparam int unsigned ExtW = 1 << SelW;

  logic [NumEvents-1:0]        ev_q;
  logic [ExtW-1:0]             ev_ext;
  logic [ExtW-1:0]             ev_prev_ext;
  logic                        idx_ok;
  logic                        wr_ok;
  logic [63:0]                 wdata64;
  logic [NumCounters*64-1:0]   cnt_flat;
  logic [NumCounters*16-1:0]   ctrl_flat;
  logic [NumCounters-1:0]      ovf_vec;
  logic [NumCounters-1:0]      irqen_vec;
  logic [63:0]                 cnt_sel;
  logic [15:0]                 ctrl_sel;

  assign ev_ext      = ExtW'({events_i, 1'b0});
  assign ev_prev_ext = ExtW'({ev_q, 1'b0});
  assign wdata64     = 64'(wdata_i);
  assign idx_ok      = ({1'b0, cnt_idx_i} < 6'(NumCounters));

  // An access errors if it targets a per-counter register of a counter that
  // does not exist, or if it touches COUNTH on a 64-bit CSR path, where the
  // whole counter already fits in COUNT. The OVF register is shared, so it
  // ignores the index.
  assign err_o = (we_i | re_i) &
                 (((reg_sel_i != 2'd3) & ~idx_ok) |
                  ((reg_sel_i == 2'd1) & (XLEN == 64)));

  assign wr_ok = we_i & ~err_o;

  // The previous-cycle event copy is the reference for edge detection. It
  // keeps sampling in debug mode, so leaving debug mode does not create a
  // false edge from stale history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ev_q <= '0;
    end else begin
      ev_q <= events_i;
    end
  end

  for (genvar i = 0; i < NumCounters; i++) begin : g_counter
    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_d;
    logic [63:0]         cnt_ext;
    logic [63:0]         wr_val;
    logic [SelW-1:0]     sel_q;
    logic                edge_q;
    logic                irqen_q;
    logic                inh_q;
    logic                ovf_q;
    logic                src;
    logic                prev;
    logic                hit;
    logic                inc;
    logic                wrap;
    logic                wr_lo;
    logic                wr_hi;
    logic                wr_ctrl;
    logic                ovf_clr;
    logic [15:0]         ctrl_word;

    assign cnt_ext = 64'(cnt_q);

    assign wr_lo   = wr_ok & (reg_sel_i == 2'd0) & (cnt_idx_i == 5'(i));
    assign wr_hi   = wr_ok & (reg_sel_i == 2'd1) & (cnt_idx_i == 5'(i));
    assign wr_ctrl = wr_ok & (reg_sel_i == 2'd2) & (cnt_idx_i == 5'(i));
    assign ovf_clr = wr_ok & (reg_sel_i == 2'd3) & wdata_i[i];

    assign src  = ev_ext[sel_q];
    assign prev = ev_prev_ext[sel_q];
    assign hit  = edge_q ? (src & ~prev) : src;
    assign inc  = hit & ~inh_q & ~debug_mode_i;

    // A software write to the count wins over a same-cycle increment. The
    // dropped increment must not report a wrap either.
    assign wrap = inc & ~(wr_lo | wr_hi) & (&cnt_q);

    // Build the post-write count. A half write on a 32-bit CSR path keeps
    // the other half from the current count, not from the incremented one.
    always_comb begin
      wr_val = cnt_ext;
      if (wr_lo) begin
        wr_val = (XLEN == 64) ? wdata64 : {cnt_ext[63:32], wdata64[31:0]};
      end else if (wr_hi) begin
        wr_val = {wdata64[31:0], cnt_ext[31:0]};
      end
    end

    always_comb begin
      if (wr_lo | wr_hi) begin
        cnt_d = wr_val[CntWidth-1:0];
      end else if (inc) begin
        cnt_d = cnt_q + CntWidth'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end

    // Counter state. When a W1C clear and a new wrap hit the same cycle,
    // the set takes priority so that the overflow is not lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q   <= '0;
        sel_q   <= '0;
        edge_q  <= 1'b0;
        irqen_q <= 1'b0;
        inh_q   <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        if (wr_ctrl) begin
          sel_q   <= wdata_i[SelW-1:0];
          edge_q  <= wdata_i[8];
          irqen_q <= wdata_i[9];
          inh_q   <= wdata_i[10];
        end
        if (wrap) begin
          ovf_q <= 1'b1;
        end else if (ovf_clr) begin
          ovf_q <= 1'b0;
        end
      end
    end

    always_comb begin
      ctrl_word             = '0;
      ctrl_word[SelW-1:0]   = sel_q;
      ctrl_word[8]          = edge_q;
      ctrl_word[9]          = irqen_q;
      ctrl_word[10]         = inh_q;
      ctrl_word[15]         = ovf_q;
    end

    assign cnt_flat[i*64 +: 64]  = cnt_ext;
    assign ctrl_flat[i*16 +: 16] = ctrl_word;
    assign ovf_vec[i]            = ovf_q;
    assign irqen_vec[i]          = irqen_q;
  end

  // Select the addressed counter. An out-of-range index matches no counter
  // and reads as 0.
  always_comb begin
    cnt_sel  = '0;
    ctrl_sel = '0;
    for (int i = 0; i < NumCounters; i++) begin
      if (cnt_idx_i == 5'(i)) begin
        cnt_sel  = cnt_flat[i*64 +: 64];
        ctrl_sel = ctrl_flat[i*16 +: 16];
      end
    end
  end

  // Read data mux. Any erroring access returns 0.
  always_comb begin
    rdata_o = '0;
    if (!err_o) begin
      case (reg_sel_i)
        2'd0: rdata_o = XLEN'(cnt_sel);
        2'd1: begin
          if (XLEN == 32) begin
            rdata_o = XLEN'(cnt_sel[63:32]);
          end
        end
        2'd2: rdata_o = XLEN'(ctrl_sel);
        default: rdata_o = XLEN'(ovf_vec);
      endcase
    end
  end

  assign irq_o = |(ovf_vec & irqen_vec);

endmodule

// File: doc/hpm_counter_bank.md
# hpm_counter_bank

Parametrised hardware performance-monitor counter bank for the CVA6 core, the generalised successor of the fixed-event counter block. Each of `NumCounters` counters selects one of `NumEvents` event lines at runtime. It counts in level or rising-edge mode, and can be inhibited individually. On wrap-around it raises a sticky overflow flag, and can raise an interrupt. It sits beside the CSR file, which drives its register-access port, and the core's event sources feed its `events_i` vector.

## Interface
- `NumCounters`, default 8: number of counters, 1..29.
- `NumEvents`, default 32: width of the event vector, 1..255.
- `CntWidth`, default 64: counter width, 33..64.
- `XLEN`, default 64: CSR data width, 32 or 64.
- `SelW`, derived, `$clog2(NumEvents+1)`: event-select field width.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset. Asynchronous, active-low.
- `debug_mode_i`, in, 1: core is in debug mode; all counting frozen.
- `events_i`, in, NumEvents: per-cycle event strobes.
- `cnt_idx_i`, in, 5: counter index for the access.
- `reg_sel_i`, in, 2: register select. 0 = COUNT, 1 = COUNTH, 2 = CTRL, 3 = OVF.
- `we_i`, in, 1: write strobe.
- `re_i`, in, 1: read strobe. Used only for error generation.
- `wdata_i`, in, XLEN: write data.
- `rdata_o`, out, XLEN: read data, combinational from `cnt_idx_i`/`reg_sel_i`.
- `err_o`, out, 1: illegal access, combinational.
- `irq_o`, out, 1: overflow interrupt.

## Operation
- Per-counter state:
  - `cnt_q[CntWidth]`
  - `sel_q[SelW]`
  - `edge_q`, `irqen_q`, `inh_q`, `ovf_q`
- Global state: `ev_q[NumEvents]`, the registered copy of `events_i` used for edge detection.
- CTRL layout: `[SelW-1:0]` sel, `[8]` edge, `[9]` irqen, `[10]` inhibit, `[15]` ovf (read-only via CTRL). Other bits read 0 and ignore writes.
- Event source selection:
  - `sel==0`: no event.
  - `sel` in `1..NumEvents`: source is `events_i[sel-1]`.
  - `sel>NumEvents`: no event. The value is stored as written.
- Hit condition:
  - Level mode: hit = source.
  - Edge mode: hit = `source & ~ev_q[sel-1]`.
- Increment rule: if hit, `!inh_q`, and `!debug_mode_i`, then `cnt_d = cnt_q + 1`, modulo 2^CntWidth.
- Overflow: `ovf_q` is set when an increment takes `cnt_q` from all-ones to 0. It is sticky.
- COUNT access:
  - XLEN=64: reads/writes `cnt_q` zero-extended/truncated to CntWidth.
  - XLEN=32: reads/writes bits `[31:0]`.
- COUNTH access:
  - XLEN=32: reads/writes bits `[CntWidth-1:32]`, zero-extended.
  - XLEN=64: reads 0. Any access sets `err_o`.
- OVF access:
  - Read returns `{..., ovf_q[NumCounters-1:0]}`; `cnt_idx_i` is ignored.
  - Write clears each `ovf_q[i]` where `wdata_i[i]==1` (W1C).
- `err_o`: asserted when (`we_i|re_i`) and `reg_sel_i!=3` and `cnt_idx_i>=NumCounters`. Also asserted for COUNTH access when XLEN=64. An erroring write has no effect, and `rdata_o` reads 0.
- Simultaneous SW write and increment on the same counter: the write wins. The increment is dropped and `ovf_q` is not set.
  - In XLEN=32, a partial write replaces only the written half. The other half keeps `cnt_q`, not the incremented value.
- Simultaneous OVF W1C and a new overflow on the same counter: the set wins (`ovf_q` stays 1).
- `irq_o = |(ovf_q & irqen_q)`. It is driven from flops only.
- Reset clears every flop to 0: `cnt_q`, `sel_q`, `edge_q`, `irqen_q`, `inh_q`, `ovf_q`, `ev_q`. `irq_o=0`.
- Reset asserted mid-operation clears state immediately (asynchronous). Nothing is retained.
- `debug_mode_i` blocks increments only. CSR writes still take effect, and `ev_q` keeps sampling.

## Timing
- Event at cycle n: the count is visible on `rdata_o` at cycle n+1.
- Write at cycle n: the new value is readable at cycle n+1.
- Read: zero latency, combinational.
- Overflow:
  - Wrap at cycle n: `ovf_q`=1 at n+1.
  - `irq_o`=1 at n+1 if `irqen_q` is set.
- `irq_o` deasserts the cycle after a W1C clear, or after `irqen_q` is cleared.
- Edge mode with a level held high for k cycles counts exactly 1. A toggle every cycle counts once per rising edge.
- Each counter may increment at most once per cycle.

## Test plan
- **Reset and level count.** Reset, then set CTRL[0].sel=3. Drive `events_i[2]` high for 10 cycles.
  - Required: COUNT[0] reads 10.
  - Required: a read after reset (before configuration) returns 0 for every register.
- **Edge mode.** Set CTRL[1]: sel=1, edge=1. Drive `events_i[0]` high 5 cycles, low 2, high 3.
  - Required: COUNT[1]=2.
- **Overflow and interrupt.**
  - Write COUNT[2]=2^CntWidth-2 (via COUNT/COUNTH for XLEN=32). Set irqen=1 and hold its event high.
  - Required: after 2 cycles, count=0, OVF bit2=1, `irq_o`=1.
  - Write OVF=0x4. Required: `irq_o`=0 next cycle.
- **Write vs increment collision.** Event active on counter 0 while writing COUNT[0]=0x55.
  - Required: next cycle reads 0x55, not 0x56.
- **Inhibit and debug freeze.**
  - Set inhibit on counter 3. Required: its count stays unchanged over 20 active cycles.
  - Clear inhibit and assert `debug_mode_i` for 5 cycles. Required: no increments.
  - Release `debug_mode_i`. Required: counting resumes.
- **Error paths.**
  - Write with `cnt_idx_i=NumCounters`. Required: `err_o`=1 and no state change.
  - XLEN=64 COUNTH read. Required: `err_o`=1, `rdata_o`=0.
  - `sel=NumEvents+1`. Required: never counts.
